// File: rtl/regfile_pkg.sv
// Shared register-file definitions: clear-engine state encoding and the
// default datapath widths also used by decode and writeback.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero-register override, write-first bypass,
// then array select, captured on an accepted read.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               accept,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]   mem,
  output logic [DATA_W-1:0]                  data
);

  logic [DATA_W-1:0] sel;

  // The zero register wins over the bypass, so a dropped write never leaks out.
  always_comb begin
    sel = mem[addr];
    if ((ZERO_REG != 0) && (addr == '0)) begin
      sel = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      sel = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (accept) begin
      data <= sel;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: N_READ registered read ports, one write port,
// and a clear engine that walks the array to zero after reset or on request.
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int DEPTH = 2**ADDR_W;

  state_e                        state;
  state_e                        state_nxt;
  logic [ADDR_W-1:0]             idx;
  logic [ADDR_W-1:0]             idx_nxt;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic                          rd_accept;
  logic                          wr_ok;

  assign busy      = (state == ST_CLEAR);
  assign rd_accept = rd_en && (state == ST_IDLE);
  assign wr_ok     = wr_en && (state == ST_IDLE) &&
                     !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (idx == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  // Contents are only ever zeroed by the walk, never by reset itself.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[idx] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_port
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .accept  (rd_accept),
      .addr    (rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem     (mem),
      .data    (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default, ZERO_REG=0 and N_READ=3 instances share
// one stimulus stream; read results are checked against an expected queue.
module tb_reg_file_param;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] e2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [14:0] rd_addr3 = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clr_req = 1'b0;

  logic [63:0] rd_data, rd_data_nz;
  logic [95:0] rd_data3;
  logic        rd_valid, rd_valid_nz, rd_valid3;
  logic        busy, busy_nz, busy3;

  reg_file_param dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy)
  );

  reg_file_param #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nz), .rd_valid(rd_valid_nz), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_nz)
  );

  reg_file_param #(.N_READ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy3)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [159:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic [63:0]  hold_m = '0;
  logic [63:0]  hold_n = '0;
  logic [95:0]  hold_3 = '0;
  logic [31:0]  m_z[32];
  logic [31:0]  m_n[32];
  vec_t         vecs[11];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sample away from the active edge.
  always @(negedge clk) begin
    logic [159:0] e;
    if (mon_en) begin
      if (rd_valid || rd_valid_nz || rd_valid3) begin
        chk("rd_valid_all", {rd_valid, rd_valid_nz, rd_valid3}, 3'b111);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          hold_m = e[63:0];
          hold_n = e[127:64];
          hold_3 = {e[159:128], e[63:0]};
          chk("rd_data_main", rd_data, hold_m);
          chk("rd_data_nz", rd_data_nz, hold_n);
          chk("rd_data_n3", rd_data3, hold_3);
        end
      end else begin
        chk("hold_main", rd_data, hold_m);
        chk("hold_nz", rd_data_nz, hold_n);
        chk("hold_n3", rd_data3, hold_3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    rd_addr = '0; rd_addr3 = '0; wr_addr = '0; wr_data = '0;
  endtask

  function automatic logic [31:0] mexp(input bit zr, input logic [4:0] a, input logic wr,
                                       input logic [4:0] wa, input logic [31:0] wd,
                                       input logic [31:0] stored);
    if (zr && a == 5'd0) return 32'd0;
    if (wr && wa == a) return wd;
    return stored;
  endfunction

  task automatic access(input logic rd, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd, input logic use_tbl, input logic [159:0] tbl);
    logic [159:0] e;
    if (rd) begin
      if (use_tbl) e = tbl;
      else e = {mexp(1'b1, a2, wr, wa, wd, m_z[a2]),
                mexp(1'b0, a1, wr, wa, wd, m_n[a1]), mexp(1'b0, a0, wr, wa, wd, m_n[a0]),
                mexp(1'b1, a1, wr, wa, wd, m_z[a1]), mexp(1'b1, a0, wr, wa, wd, m_z[a0])};
      exp_q.push_back(e);
    end
    if (wr) begin
      if (wa != 5'd0) m_z[wa] = wd;
      m_n[wa] = wd;
    end
    rd_en = rd; rd_addr = {a1, a0}; rd_addr3 = {a2, a1, a0};
    wr_en = wr; wr_addr = wa; wr_data = wd;
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_z[i] = '0;
      m_n[i] = '0;
    end
  endtask

  task automatic do_reset(input int cycles);
    mon_en = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (cycles) tick();
    exp_q.delete();
    hold_m = '0; hold_n = '0; hold_3 = '0;
    clear_model();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Busy must stay high for exactly 32 samples; with noise, accesses and a
  // repeated clear request are thrown at the engine and must all be ignored.
  task automatic check_busy(input bit noise);
    for (int i = 0; i < 32; i++) begin
      chk("busy_high", {busy, busy_nz, busy3}, 3'b111);
      if (noise) begin
        rd_en = 1'($urandom_range(0, 1));
        wr_en = 1'($urandom_range(0, 1));
        rd_addr = 10'($urandom_range(0, 1023));
        rd_addr3 = 15'($urandom_range(0, 32767));
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = $urandom;
        clr_req = (i == 5);
      end
      tick();
    end
    idle_inputs();
    chk("busy_low", {busy, busy_nz, busy3}, 3'b000);
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) begin
      access(1'b1, 5'(a), 5'(31 - a), 5'(a), 1'b0, 5'd0, 32'd0, 1'b0, '0);
    end
    idle_inputs();
    tick();
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rd, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] e2);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.e0 = e0; v.e1 = e1; v.n0 = n0; v.n1 = n1; v.e2 = e2;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 7, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[2]  = mk(1, 4, 32'hA5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 3, 32'h12345678, 1, 3, 4, 3, 32'h12345678, 32'hA5, 32'h12345678, 32'hA5, 32'h12345678);
    vecs[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    vecs[6]  = mk(0, 0, 0, 1, 3, 7, 4, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hA5);
    vecs[7]  = mk(1, 5, 32'hCAFEF00D, 1, 5, 0, 5, 32'hCAFEF00D, 0, 32'hCAFEF00D, 32'hFFFFFFFF, 32'hCAFEF00D);
    vecs[8]  = mk(1, 0, 32'h0BADF00D, 1, 0, 1, 0, 0, 0, 32'h0BADF00D, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 5, 31, 0, 32'hCAFEF00D, 32'h0BADF00D, 32'hCAFEF00D, 0);
    vecs[10] = mk(0, 0, 0, 1, 31, 4, 7, 0, 32'hA5, 0, 32'hA5, 32'hDEADBEEF);

    // Reset then idle: busy for 32 samples, all entries read back zero.
    do_reset(2);
    chk("reset_rd_valid", {rd_valid, rd_valid_nz, rd_valid3}, 3'b000);
    check_busy(1'b0);
    read_all();

    // Directed write/read, bypass and zero-register vectors.
    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].wr, vecs[i].wa, vecs[i].wd,
             1'b1, {vecs[i].e2, vecs[i].n1, vecs[i].n0, vecs[i].e1, vecs[i].e0});
    end
    idle_inputs();
    tick();

    // Random mixed traffic against the model.
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom, 1'b0, '0);
    end

    // Clear request with a same-edge read and write.
    for (int a = 1; a < 32; a++) begin
      access(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'(a), 32'(a * 32'h11), 1'b0, '0);
    end
    clr_req = 1'b1;
    access(1'b1, 5'd2, 5'd9, 5'd2, 1'b1, 5'd2, 32'h55, 1'b0, '0);
    clr_req = 1'b0;
    clear_model();
    check_busy(1'b1);
    read_all();

    // Reset asserted in the middle of a clear walk.
    for (int a = 1; a < 32; a++) begin
      access(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'(a), $urandom, 1'b0, '0);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("busy_pre_reset", {busy, busy_nz, busy3}, 3'b111);
      tick();
    end
    do_reset(1);
    check_busy(1'b0);
    read_all();

    tick();
    tick();
    chk("queue_drained", 160'(exp_q.size()), 160'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised general-purpose register file for the datapath. It replaces the fixed 32x32, two-read, clock-sampled register bank. Added behaviour:
- configurable width, depth and read-port count;
- one-cycle registered reads with a valid flag and write-first bypass;
- optional hardwired zero register;
- a sequential clear engine that zeroes the array after reset or on request.

It sits between the decode stage (addresses) and the execute and writeback stages (data).

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries
- N_READ, 2: number of read ports, minimum 1
- ZERO_REG, 1: when 1, entry 0 always reads 0 and ignores writes
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_en  in  1  read strobe, shared by all ports
- rd_addr  in  N_READ*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  N_READ*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
- rd_valid  out  1  rd_data updated by a read accepted on the previous edge
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  single-cycle request to zero the whole array
- busy  out  1  clear engine active; reads and writes ignored

## Operation
- FSM states: CLEAR, IDLE. A clear index `idx` of ADDR_W bits walks the array in CLEAR.
- Reset (rst_n=0 at an edge):
  - state goes to CLEAR, idx=0;
  - rd_data=0, rd_valid=0;
  - busy=1 from the next cycle.
- Array contents are not reset directly. The clear engine zeroes them.
- CLEAR:
  - each edge writes 0 to mem[idx], then idx increments;
  - on the edge that writes mem[DEPTH-1], the FSM goes to IDLE;
  - rd_en and wr_en are ignored, rd_valid=0, rd_data holds its value.
- IDLE plus clr_req: go to CLEAR with idx=0.
  - A read accepted on that same edge still completes.
  - A write accepted on that same edge is performed but is later zeroed.
  - clr_req while busy is ignored. It does not restart the walk.
- Write (IDLE, wr_en=1): mem[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (IDLE, rd_en=1), per port p:
  - rd_data[p] <= 0 if ZERO_REG=1 and rd_addr[p]=0;
  - else wr_data if wr_en=1 and wr_addr==rd_addr[p] (write-first bypass);
  - else mem[rd_addr[p]].
- rd_valid follows the read strobe:
  - rd_valid <= 1 on an accepted read;
  - rd_valid <= 0 otherwise;
  - rd_data holds its last value when no read is accepted.
- Multiple ports may share an address. Each port resolves independently and returns identical data.

## Timing
- Read latency is 1 cycle. Address is sampled at edge N; rd_data and rd_valid are valid after edge N, until edge N+1.
- Write latency is 1 cycle to the array. The bypass makes a same-cycle read see the new value.
- Clear duration after reset deasserts:
  - busy is high for exactly DEPTH cycles;
  - the first accepted access is on edge DEPTH+1 after the first edge with rst_n=1.
- Clear duration for clr_req:
  - clr_req is sampled at edge N;
  - busy is high from after edge N through edge N+DEPTH;
  - IDLE from edge N+DEPTH onward.
- Reset asserted mid-clear: the walk restarts at idx=0 and the full DEPTH cycles apply again.
- Outputs are registered only. There are no combinational input-to-output paths.

## Structure
- Shared package `regfile_pkg`:
  - FSM state enum (ST_CLEAR, ST_IDLE);
  - default DATA_W and ADDR_W constants shared with decode and writeback.
- One sub-module: `regfile_read_port`, instantiated N_READ times.
  - Does the zero-reg check, the bypass compare and the array select for a single port.
  - Has its registered data output.
- The array, write logic and clear FSM stay in the top module.

## Test plan
Defaults apply unless noted.
1. Reset then idle:
   - rst_n low 2 cycles, then high;
   - busy=1 for 32 cycles, then 0;
   - reads of all 32 addresses return 0 with rd_valid=1 one cycle after each rd_en.
2. Write/read:
   - write 0xDEADBEEF to addr 7;
   - next cycle rd_addr={7,7}, rd_en=1;
   - both ports give 0xDEADBEEF one cycle later.
3. Bypass:
   - same cycle wr_en=1, wr_addr=3, wr_data=0x12345678, rd_addr={3,4}, rd_en=1 (addr 4 holds 0xA5);
   - next cycle port0=0x12345678, port1=0xA5.
4. Zero reg:
   - write 0xFFFFFFFF to addr 0, then read addr 0 → 0;
   - with ZERO_REG=0 the same sequence → 0xFFFFFFFF.
5. Clear request:
   - fill addrs 1..31 with addr*0x11;
   - pulse clr_req with a simultaneous write 0x55 to addr 2;
   - busy=1 for 32 cycles;
   - rd_en/wr_en during busy have no effect (rd_valid=0);
   - afterwards every address reads 0.
6. Reset mid-clear:
   - pulse clr_req, at cycle 10 assert rst_n low 1 cycle;
   - busy stays high for 32 cycles after release (42 total);
   - all entries read 0; N_READ=3 variant repeats scenario 2 on port 2.
